// File: rtl/mips_pc_pkg.sv
// Shared defaults and redirect-select encoding for the fetch PC sequencer.
package mips_pc_pkg;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned IMM_W_DEF  = 16;
  localparam int unsigned JIDX_W_DEF = 26;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  // Which source feeds the next fetch PC
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop returns the newest; only built when PC_SEQ_RAS_EN is defined.
module pc_ras #(
  parameter int ADDR_W    = 30,
  parameter int RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  // ptr_q is the next write slot, so the newest entry sits one below it
  assign o_top   = mem_q[ptr_q - PTR_W'(1)];
  assign o_empty = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (i_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != (PTR_W+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (i_pop && !o_empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[ptr_q] <= i_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and decode-stage next-PC resolution (BEQ/BNE/J/JAL/JR).
// Define PC_SEQ_RAS_EN to add a return-address stack for JAL/JR-return pairs.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                IMM_W     = IMM_W_DEF,
  parameter int                JIDX_W    = JIDX_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_valid,
  input  logic              i_Beq,
  input  logic              i_Bne,
  input  logic              i_Zero,
  input  logic              i_J,
  input  logic              i_Jal,
  input  logic              i_Jr,
  input  logic              i_Ret,
  input  logic [JIDX_W-1:0] i_imm,
  input  logic [ADDR_W-1:0] i_rs_target,
  output logic [ADDR_W-1:0] o_PC,
  output logic [ADDR_W-1:0] o_dec_PC1,
  output logic              o_PCSrc,
  output logic              o_flush
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] dec_pc1_q, dec_pc1_d;
  logic [ADDR_W-1:0] seq_pc, br_pc, jmp_pc, jr_pc, next_pc, imm_sext;
  logic              br_cond, take;
  pc_sel_e           sel;

  assign imm_sext = {{(ADDR_W-IMM_W){i_imm[IMM_W-1]}}, i_imm[IMM_W-1:0]};
  assign seq_pc   = pc_q + ADDR_W'(1);
  assign br_pc    = dec_pc1_q + imm_sext;
  assign jmp_pc   = {dec_pc1_q[ADDR_W-1:JIDX_W], i_imm};
  assign br_cond  = (i_Beq & i_Zero) | (i_Bne & ~i_Zero);
  // Reset forces the redirect low so an in-flight branch cannot leak out
  assign take     = i_rst_n & i_valid & ~i_stall & (i_Jr | i_J | i_Jal | br_cond);

`ifdef PC_SEQ_RAS_EN
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign ras_push = (sel == SEL_JMP) & i_Jal;
  assign ras_pop  = (sel == SEL_JR) & i_Ret & ~ras_empty;
  assign jr_pc    = ras_pop ? ras_top : i_rs_target;

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (ras_push),
    .i_pop  (ras_pop),
    .i_data (dec_pc1_q),
    .o_top  (ras_top),
    .o_empty(ras_empty)
  );
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(RAS_DEPTH) ^ {31'b0, i_Ret};
  assign jr_pc      = i_rs_target;
`endif

  always_comb begin
    sel = SEL_SEQ;
    if (take) begin
      if (i_Jr)              sel = SEL_JR;
      else if (i_J || i_Jal) sel = SEL_JMP;
      else                   sel = SEL_BR;
    end
    case (sel)
      SEL_BR:  next_pc = br_pc;
      SEL_JMP: next_pc = jmp_pc;
      SEL_JR:  next_pc = jr_pc;
      default: next_pc = seq_pc;
    endcase
    pc_d      = pc_q;
    dec_pc1_d = dec_pc1_q;
    if (!i_stall) begin
      pc_d      = next_pc;
      dec_pc1_d = seq_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q      <= RESET_PC;
      dec_pc1_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      dec_pc1_q <= dec_pc1_d;
    end
  end

  assign o_PC      = pc_q;
  assign o_dec_PC1 = dec_pc1_q;
  assign o_PCSrc   = take;
  assign o_flush   = take;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised + directed bench for pc_sequencer against a behavioural next-PC model.
module tb_pc_sequencer;

  localparam logic [29:0] RPC = 30'h100;

  logic        clk = 1'b0;
  logic        i_rst_n, i_stall, i_valid, i_Beq, i_Bne, i_Zero, i_J, i_Jal, i_Jr, i_Ret;
  logic [25:0] i_imm;
  logic [29:0] i_rs_target;
  logic [29:0] o_PC, o_dec_PC1;
  logic        o_PCSrc, o_flush;

  int n_vec = 0;
  int n_mis = 0;

  logic [29:0] m_pc, m_dec;
  logic [29:0] ras_q[$];
  logic        last_src;

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_valid(i_valid),
    .i_Beq(i_Beq), .i_Bne(i_Bne), .i_Zero(i_Zero), .i_J(i_J), .i_Jal(i_Jal),
    .i_Jr(i_Jr), .i_Ret(i_Ret), .i_imm(i_imm), .i_rs_target(i_rs_target),
    .o_PC(o_PC), .o_dec_PC1(o_dec_PC1), .o_PCSrc(o_PCSrc), .o_flush(o_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    i_stall = 0; i_valid = 0; i_Beq = 0; i_Bne = 0; i_Zero = 0;
    i_J = 0; i_Jal = 0; i_Jr = 0; i_Ret = 0; i_imm = '0; i_rs_target = '0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    logic        br_t, exp_take;
    logic [29:0] nxt;
    #1;
    br_t     = (i_Beq && i_Zero) || (i_Bne && !i_Zero);
    exp_take = i_valid && !i_stall && (i_Jr || i_J || i_Jal || br_t);
    nxt      = m_pc + 30'd1;
    if (exp_take) begin
      if (i_Jr) begin
        nxt = i_rs_target;
`ifdef PC_SEQ_RAS_EN
        if (i_Ret && ras_q.size() > 0) nxt = ras_q.pop_back();
`endif
      end else if (i_J || i_Jal) begin
        nxt = {m_dec[29:26], i_imm};
`ifdef PC_SEQ_RAS_EN
        if (i_Jal) begin
          ras_q.push_back(m_dec);
          if (ras_q.size() > 4) void'(ras_q.pop_front());
        end
`endif
      end else begin
        nxt = m_dec + {{14{i_imm[15]}}, i_imm[15:0]};
      end
    end
    chk("pc", 32'(o_PC), 32'(m_pc));
    chk("dec_pc1", 32'(o_dec_PC1), 32'(m_dec));
    chk("pcsrc", 32'(o_PCSrc), 32'(exp_take));
    chk("flush", 32'(o_flush), 32'(exp_take));
    last_src = o_PCSrc;
    @(posedge clk);
    if (!i_stall) begin
      m_dec = m_pc + 30'd1;
      m_pc  = nxt;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc  = RPC;
    m_dec = RPC;
    ras_q.delete();
  endtask

  initial begin
    clr();
    i_rst_n = 0;
    i_valid = 1; i_Jr = 1; i_rs_target = 30'h3AB;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_pc", 32'(o_PC), 32'h100);
    chk("rst_dec", 32'(o_dec_PC1), 32'h100);
    chk("rst_pcsrc", 32'(o_PCSrc), 32'h0);
    chk("rst_flush", 32'(o_flush), 32'h0);
    @(negedge clk);
    clr();
    i_rst_n = 1;

    // Sequential fetch after reset
    for (int i = 0; i < 3; i++) begin
      chk("t1_pc", 32'(o_PC), 32'h100 + i);
      cycle();
      chk("t1_src", 32'(last_src), 32'h0);
    end

    // Get dec_PC1 to 0x105, then taken and not-taken BEQ
    i_valid = 1; i_J = 1; i_imm = 26'h104; cycle(); clr();
    cycle();
    chk("t2_dec", 32'(o_dec_PC1), 32'h105);
    i_valid = 1; i_Beq = 1; i_Zero = 1; i_imm = 26'h0FFFE; cycle();
    chk("t2_src", 32'(last_src), 32'h1);
    chk("t2_pc", 32'(o_PC), 32'h103);
    i_Zero = 0; cycle(); clr();
    chk("t2_nt_src", 32'(last_src), 32'h0);
    chk("t2_nt_pc", 32'(o_PC), 32'h104);

    // BNE wrap at the top of the address space
    i_valid = 1; i_Jr = 1; i_rs_target = 30'h3FFFFFFD; cycle(); clr();
    cycle();
    chk("t3_dec", 32'(o_dec_PC1), 32'h3FFFFFFE);
    i_valid = 1; i_Bne = 1; i_Zero = 0; i_imm = 26'h0004; cycle(); clr();
    chk("t3_pc", 32'(o_PC), 32'h2);

    // J keeps upper dec_PC1 bits; JR wins over J
    i_valid = 1; i_Jr = 1; i_rs_target = 30'h2000000F; cycle(); clr();
    cycle();
    i_valid = 1; i_J = 1; i_imm = 26'h40; cycle(); clr();
    chk("t4_j_pc", 32'(o_PC), 32'h20000040);
    i_valid = 1; i_J = 1; i_Jr = 1; i_imm = 26'h77; i_rs_target = 30'h12345; cycle(); clr();
    chk("t4_jr_pc", 32'(o_PC), 32'h12345);

    // Taken branch held by stall for three cycles
    cycle();
    i_valid = 1; i_Beq = 1; i_Zero = 1; i_imm = 26'h5; i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_hold_pc", 32'(o_PC), 32'h12346);
      chk("t5_hold_src", 32'(last_src), 32'h0);
    end
    i_stall = 0; cycle(); clr();
    chk("t5_src", 32'(last_src), 32'h1);
    chk("t5_pc", 32'(o_PC), 32'h1234B);
    cycle();
    chk("t5_once", 32'(last_src), 32'h0);

    // Reset in the middle of a redirect
    i_valid = 1; i_J = 1; i_imm = 26'h3;
    #1;
    chk("mid_src_pre", 32'(o_PCSrc), 32'h1);
    i_rst_n = 0;
    #1;
    chk("mid_pc", 32'(o_PC), 32'h100);
    chk("mid_dec", 32'(o_dec_PC1), 32'h100);
    chk("mid_src", 32'(o_PCSrc), 32'h0);
    @(posedge clk);
    @(negedge clk);
    clr();
    i_rst_n = 1;
    model_reset();
    cycle();
    chk("mid_after_pc", 32'(o_PC), 32'h101);

`ifdef PC_SEQ_RAS_EN
    model_reset();
    i_rst_n = 0; #1; i_rst_n = 1;
    i_valid = 1; i_J = 1; i_imm = 26'h1FF; cycle(); clr();
    cycle();
    chk("t6_dec", 32'(o_dec_PC1), 32'h200);
    i_valid = 1; i_Jal = 1; i_imm = 26'h300; cycle(); clr();
    cycle();
    i_valid = 1; i_Jr = 1; i_Ret = 1; i_rs_target = 30'h999; cycle(); clr();
    chk("t6_ret_pc", 32'(o_PC), 32'h200);
    for (int k = 1; k <= 5; k++) begin
      i_valid = 1; i_Jal = 1; i_imm = 26'h400 + 26'(k * 16); cycle(); clr();
      cycle();
    end
    for (int k = 0; k < 5; k++) begin
      i_valid = 1; i_Jr = 1; i_Ret = 1; i_rs_target = 30'h999; cycle(); clr();
      chk("t6_pop_pc", 32'(o_PC), (k < 4) ? 32'h441 - 32'(k * 16) : 32'h999);
      cycle();
    end
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      i_stall     = ($urandom_range(0, 9) == 0);
      i_valid     = ($urandom_range(0, 9) < 8);
      i_Beq       = ($urandom_range(0, 4) == 0);
      i_Bne       = ($urandom_range(0, 4) == 0);
      i_Zero      = $urandom_range(0, 1) == 1;
      i_J         = ($urandom_range(0, 7) == 0);
      i_Jal       = ($urandom_range(0, 7) == 0);
      i_Jr        = ($urandom_range(0, 7) == 0);
      i_Ret       = $urandom_range(0, 1) == 1;
      i_imm       = 26'($urandom);
      i_rs_target = 30'($urandom);
      cycle();
    end
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
